// File: rtl/scan_pkg.sv
// Shared types and constants for the display and keypad scan controllers.
package scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    localparam int DIGITS        = 4;
    localparam int SEL_W         = 2;
    localparam int SLOT_DEFAULT  = 50000;
    localparam int BLANK_DEFAULT = 500;

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Bundle between the scan controller and the decoder / segment-data mux side.
interface digit_scan_ctrl_if;
    import scan_pkg::*;

    logic              EN;
    logic [DIGITS-1:0] MASK;
    logic              A;
    logic              B;
    logic              G_L;
    logic [SEL_W-1:0]  SEL;
    logic              FRAME;

    modport master (
        output EN,
        output MASK,
        input  A,
        input  B,
        input  G_L,
        input  SEL,
        input  FRAME
    );

    modport slave (
        input  EN,
        input  MASK,
        output A,
        output B,
        output G_L,
        output SEL,
        output FRAME
    );

endinterface

// File: rtl/scan_slot_timer.sv
// Mod-SLOT slot timer with a terminal-count flag; shared with the keypad scanner.
module scan_slot_timer
    import scan_pkg::*;
#(
    parameter int SLOT = SLOT_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     RESET_L,
    input  logic                     clr,
    input  logic                     run,
    output logic [$clog2(SLOT)-1:0]  t,
    output logic                     last
);

    localparam int TW = $clog2(SLOT);
    localparam logic [TW-1:0] T_LAST = TW'(SLOT - 1);

    assign last = (t == T_LAST);

    // clr wins over run so a stop or restart always lands on t = 0
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            t <= '0;
        end else if (clr) begin
            t <= '0;
        end else if (run) begin
            t <= last ? '0 : t + 1'b1;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// 4-digit time-multiplexed scan controller driving a 2-to-4 decoder (A, B, G_L).
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int SLOT  = SLOT_DEFAULT,
    parameter int BLANK = BLANK_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET_L,
    digit_scan_ctrl_if.slave  bus
);

    localparam int TW = $clog2(SLOT);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

    scan_state_e       state;
    logic [SEL_W-1:0]  sel_q;
    logic [DIGITS-1:0] mask_q;
    logic              g_l_q;
    logic              frame_q;
    logic [TW-1:0]     t;
    logic              last;
    logic              clr;
    logic              run;

    assign clr = (state == IDLE) || !bus.EN;
    assign run = (state == SCAN) && bus.EN;

    scan_slot_timer #(.SLOT(SLOT)) u_timer (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .clr     (clr),
        .run     (run),
        .t       (t),
        .last    (last)
    );

    // G_L is registered from the timer value it will see after this edge, so
    // a slot boundary always lands in blanking and the address never moves
    // while the decoder is enabled.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state   <= IDLE;
            sel_q   <= '0;
            mask_q  <= '0;
            g_l_q   <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    g_l_q   <= 1'b1;
                    frame_q <= 1'b0;
                    if (bus.EN) begin
                        state   <= SCAN;
                        sel_q   <= '0;
                        mask_q  <= bus.MASK;
                        frame_q <= 1'b1;
                    end
                end
                SCAN: begin
                    frame_q <= 1'b0;
                    if (!bus.EN) begin
                        state <= IDLE;
                        g_l_q <= 1'b1;
                    end else if (last) begin
                        sel_q   <= sel_q + 1'b1;
                        mask_q  <= bus.MASK;
                        frame_q <= (sel_q == SEL_LAST);
                        g_l_q   <= 1'b1;
                    end else if (t < BLANK_LAST) begin
                        g_l_q <= 1'b1;
                    end else begin
                        g_l_q <= ~mask_q[sel_q];
                    end
                end
                default: begin
                    state   <= IDLE;
                    g_l_q   <= 1'b1;
                    frame_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A     = sel_q[0];
    assign bus.B     = sel_q[1];
    assign bus.SEL   = sel_q;
    assign bus.G_L   = g_l_q;
    assign bus.FRAME = frame_q;

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexing scan controller for a 4-digit active-low-select display. It sits directly upstream of the dual 2-to-4 decoder half: it drives the decoder's `A`, `B` and `G_L` inputs, so exactly one `Y_L` line goes low per time slot. A blanking interval at the start of every slot keeps the address from ever changing while the decoder is enabled. It also exports the digit index, which the segment-data mux uses, and a frame-start strobe.

## Interface
Parameters:
- `SLOT`, default 50000: clock cycles per digit slot. Legal range is `SLOT ≥ 2`.
- `BLANK`, default 500: cycles at the start of each slot with `G_L` forced high. Legal range is `1 ≤ BLANK < SLOT`.

Ports:
- `CLK`  in  1  system clock; all logic is rising-edge.
- `RESET_L`  in  1  asynchronous, active-low reset.
- `EN`  in  1  scan enable.
- `MASK`  in  4  per-digit display enable; bit i = 1 means digit i is shown.
- `A`  out  1  decoder address LSB (= `SEL[0]`).
- `B`  out  1  decoder address MSB (= `SEL[1]`).
- `G_L`  out  1  decoder enable, active-low.
- `SEL`  out  2  current digit index, for the data mux.
- `FRAME`  out  1  one-cycle pulse at the start of each digit-0 slot.

## Operation
- **States:**
  - `IDLE`: scanning stopped.
  - `SCAN`: scanning. Inside a slot, the slot timer `t` counts 0..SLOT-1.
- **Reset values** (while `RESET_L` = 0, effective immediately):
  - State = `IDLE`, `t` = 0, `SEL` = 0.
  - `A` = `B` = 0, `G_L` = 1, `FRAME` = 0.
  - `mask_q` = 0000.
- **In `IDLE`:**
  - `G_L` = 1 and `SEL` holds its value.
  - If `EN` = 1 at an edge: go to `SCAN`, set `SEL` = 0, `t` = 0, latch `mask_q` ← `MASK`, and pulse `FRAME`.
- **In `SCAN`:**
  - `G_L` = 1 while `t` < `BLANK`; otherwise `G_L` = ~`mask_q[SEL]`.
  - At `t` = SLOT-1 the next edge does all of the following:
    - `t` ← 0.
    - `SEL` ← `SEL`+1 mod 4, wrapping 3→0.
    - `mask_q` ← `MASK`.
    - `FRAME` = 1 for that one cycle if the new `SEL` is 0.
- **Masked digit:** its slot still takes its full `SLOT` cycles with `G_L` = 1 throughout. The frame period is constant at 4·SLOT cycles.
- **`MASK` changes mid-slot:** ignored until the next slot boundary.
- **`EN` = 0 in `SCAN`:**
  - Next edge: state `IDLE`, `G_L` = 1, `SEL`/`A`/`B` unchanged on that same edge.
  - A later `EN` = 1 restarts at `SEL` = 0 with a `FRAME` pulse.
- **`EN` toggling on a slot-boundary edge:** `EN` = 0 takes priority. No `SEL` increment and no `FRAME` pulse.
- **Invariant:** `A`, `B` and `SEL` change only on edges where the new `G_L` is 1.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- **Start-up latency:** `EN` sampled high at edge k gives:
  - `FRAME` = 1 and `SEL` = 0 after edge k.
  - First `G_L` = 0 after edge k+BLANK, if `MASK[0]` = 1.
- **Per slot:** `G_L` is high for `BLANK` cycles, then low for SLOT−BLANK cycles when the digit is enabled.
- `FRAME` period is 4·SLOT cycles.
- **Stop latency:** `EN` low at edge k gives `G_L` = 1 after edge k.
- **Reset mid-slot:** reset is asynchronous, so `G_L` goes high without waiting for a clock edge.
- **Timer width:** `$clog2(SLOT)` bits. The counter never exceeds SLOT-1.

## Structure
- **Shared package/header `scan_pkg`:**
  - State encoding: `IDLE` = 1'b0, `SCAN` = 1'b1.
  - `DIGITS` = 4 and `SEL_W` = 2.
  - Default `SLOT`/`BLANK` values.
- **Sub-module `scan_slot_timer`:**
  - Parameterised mod-`SLOT` counter.
  - Inputs: `CLK`, `RESET_L`, `clr`, `run`.
  - Outputs: `t` and a `last` flag (`t` == SLOT-1).
  - Reusable for the keypad scanner.
- **Top level** holds the FSM, the `SEL` register, `mask_q` and the output flops.

## Test plan
Directed scenarios run with `SLOT` = 8 and `BLANK` = 2.
1. **Reset:** assert `RESET_L` = 0 mid-slot while `G_L` = 0 → `G_L` = 1, `A`/`B`/`SEL` = 0 and `FRAME` = 0 immediately, without a clock edge.
2. **Full scan:** `EN` = 1, `MASK` = 1111 → `SEL` steps 0,1,2,3,0 every 8 cycles; each slot shows `G_L` = 1,1 then 0×6; `FRAME` pulses every 32 cycles, aligned to `SEL` = 0.
3. **Masked digits:** `MASK` = 0101 → `G_L` = 0 only in slots 0 and 2; slots 1 and 3 hold `G_L` = 1 for all 8 cycles; frame is still 32 cycles.
4. **Mid-slot mask change:** change `MASK` from 1111 to 0000 at `t` = 4 of slot 1 → slot 1 stays low through `t` = 7; slot 2 is fully blanked.
5. **Stop and restart:** drop `EN` at `t` = 5 of slot 2 → next cycle `G_L` = 1 and `SEL` stays 2. Re-raise `EN` → `SEL` = 0, `FRAME` = 1, `G_L` goes low after 2 cycles.
6. **Address-stability assertion:** over a 1000-cycle random run of `EN`/`MASK`, every cycle in which `SEL` changes has `G_L` = 1. `A` = `SEL[0]` and `B` = `SEL[1]` always.
